// File: rtl/matrix_column_scanner_if.sv
// Signal bundle between the LED-matrix column scanner and its surroundings.
// The master side supplies the image and control; the slave side is the scanner.
interface matrix_column_scanner_if;
   logic       enable;
   logic       blink;
   logic [6:0] column_4;
   logic [6:0] column_3;
   logic [6:0] column_2;
   logic [6:0] column_1;
   logic [6:0] column_0;
   logic [6:0] rows;
   logic [4:0] column_select;
   logic       frame_done;
   logic [1:0] dbg_state;

   modport master (
      output enable, blink, column_4, column_3, column_2, column_1, column_0,
      input  rows, column_select, frame_done, dbg_state
   );

   modport slave (
      input  enable, blink, column_4, column_3, column_2, column_1, column_0,
      output rows, column_select, frame_done, dbg_state
   );
endinterface

// File: rtl/matrix_column_scanner.sv
// Multiplexed 5x7 LED matrix scanner: columns 4..0 each get a blank gap then a
// drive window; the image is latched once per frame and can optionally blink.
module matrix_column_scanner #(
   parameter int CLKS_PER_COLUMN = 50000,
   parameter int BLANK_CLKS      = 16,
   parameter int BLINK_FRAMES    = 100
) (
   input  logic                    clock,
   input  logic                    reset_n,
   matrix_column_scanner_if.slave  bus
);

   localparam int PW = (CLKS_PER_COLUMN > 1) ? $clog2(CLKS_PER_COLUMN) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PS_LAST       = PW'(CLKS_PER_COLUMN - 1);
   localparam logic [PW-1:0] PS_BLANK_LAST = PW'(BLANK_CLKS - 1);
   localparam logic [BW-1:0] BL_LAST       = BW'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_ps;
   logic [2:0]    r_idx;
   logic [BW-1:0] r_blink_cnt;
   logic          r_visible;
   logic [6:0]    r_shadow [0:4];
   logic [6:0]    r_rows;
   logic [4:0]    r_col_sel;
   logic          r_frame_done;

   state_t        w_state_nxt;
   logic [PW-1:0] w_ps_nxt;
   logic [2:0]    w_idx_nxt;
   logic          w_load;
   logic          w_wrap;
   logic          w_abort;
   logic [BW-1:0] w_blink_cnt_nxt;
   logic          w_visible_nxt;
   logic [6:0]    w_rows_nxt;
   logic [4:0]    w_col_sel_nxt;
   logic          w_frame_done_nxt;
   logic [6:0]    w_cols [0:4];

   assign w_cols[0] = bus.column_0;
   assign w_cols[1] = bus.column_1;
   assign w_cols[2] = bus.column_2;
   assign w_cols[3] = bus.column_3;
   assign w_cols[4] = bus.column_4;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_ps         <= '0;
         r_idx        <= 3'd4;
         r_blink_cnt  <= '0;
         r_visible    <= 1'b1;
         for (int k = 0; k < 5; k++) r_shadow[k] <= 7'h7F;
         r_rows       <= 7'h7F;
         r_col_sel    <= 5'b00000;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_ps         <= w_ps_nxt;
         r_idx        <= w_idx_nxt;
         r_blink_cnt  <= w_blink_cnt_nxt;
         r_visible    <= w_visible_nxt;
         if (w_load) begin
            for (int k = 0; k < 5; k++) r_shadow[k] <= w_cols[k];
         end
         r_rows       <= w_rows_nxt;
         r_col_sel    <= w_col_sel_nxt;
         r_frame_done <= w_frame_done_nxt;
      end
   end

   // Slot sequencing: the prescaler runs across BLANK and DRIVE of one slot.
   always_comb begin
      w_state_nxt = r_state;
      w_ps_nxt    = r_ps;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      w_wrap      = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.enable) begin
               w_state_nxt = ST_BLANK;
               w_ps_nxt    = '0;
               w_idx_nxt   = 3'd4;
               w_load      = 1'b1;
            end
         end
         ST_BLANK: begin
            if (!bus.enable) begin
               w_state_nxt = ST_IDLE;
               w_ps_nxt    = '0;
               w_abort     = 1'b1;
            end else begin
               w_ps_nxt = r_ps + 1'b1;
               if (r_ps == PS_BLANK_LAST) w_state_nxt = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (!bus.enable) begin
               w_state_nxt = ST_IDLE;
               w_ps_nxt    = '0;
               w_abort     = 1'b1;
            end else if (r_ps == PS_LAST) begin
               w_state_nxt = ST_BLANK;
               w_ps_nxt    = '0;
               if (r_idx == 3'd0) begin
                  w_idx_nxt = 3'd4;
                  w_load    = 1'b1;
                  w_wrap    = 1'b1;
               end else begin
                  w_idx_nxt = r_idx - 3'd1;
               end
            end else begin
               w_ps_nxt = r_ps + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_ps_nxt    = '0;
         end
      endcase
   end

   // Blink bookkeeping advances only on frame wraps; blink=0 always wins.
   always_comb begin
      w_blink_cnt_nxt = r_blink_cnt;
      w_visible_nxt   = r_visible;
      if (!bus.blink) begin
         w_blink_cnt_nxt = '0;
         w_visible_nxt   = 1'b1;
      end else if (w_abort) begin
         w_blink_cnt_nxt = '0;
      end else if (w_wrap) begin
         if (r_blink_cnt == BL_LAST) begin
            w_blink_cnt_nxt = '0;
            w_visible_nxt   = ~r_visible;
         end else begin
            w_blink_cnt_nxt = r_blink_cnt + 1'b1;
         end
      end
   end

   // Outputs are decoded from next-state values so they register with the FSM.
   always_comb begin
      w_rows_nxt       = 7'h7F;
      w_col_sel_nxt    = 5'b00000;
      w_frame_done_nxt = w_wrap;
      if (w_state_nxt == ST_DRIVE && w_visible_nxt) begin
         w_rows_nxt    = r_shadow[w_idx_nxt];
         w_col_sel_nxt = 5'b00001 << w_idx_nxt;
      end
   end

   assign bus.rows          = r_rows;
   assign bus.column_select = r_col_sel;
   assign bus.frame_done    = r_frame_done;
   assign bus.dbg_state     = r_state;

endmodule
